rr_response_router: RTL and testbench
=====================================

# rr_response_router

Return-path stage downstream of the round-robin scheduling kernel and the PLM banks. For every kernel (bank × port), it carries the granted consumer's identity alongside the PLM read latency. It then steers each bank port's read data back to the consumer that issued the request, presenting one registered response port per consumer. It completes the request → schedule → PLM → response loop of the memory subsystem.

## Interface
Parameters:
- VALUE_WIDTH, 8, width of PLM read data / response data
- NCONSUMERS, 2, number of consumers; CID_WIDTH = max(1, $clog2(NCONSUMERS))
- NBANKS, 1, number of PLM banks
- NPORTS, 1, ports per bank (1 or 2; other values fail an initial assertion)
- PLM_LATENCY, 1, PLM read latency in cycles (≥ 1; 0 fails an initial assertion)
- Derived: NKERNELS = NBANKS * NPORTS; kernel index k = bank * NPORTS + port

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- grant_valid  input  NKERNELS  kernel k issued an operation to its PLM port this cycle
- grant_read  input  NKERNELS  the issued operation is a read (0 = write, no response)
- grant_consumer  input  [CID_WIDTH-1:0] x NKERNELS (unpacked)  consumer id owning kernel k's operation
- plm_rdata  input  [VALUE_WIDTH-1:0] x NKERNELS (unpacked)  PLM read data of kernel k
- resp_valid  output  NCONSUMERS  registered; response delivered to consumer c this cycle
- resp_data  output  [VALUE_WIDTH-1:0] x NCONSUMERS (unpacked)  registered response data
- route_error  output  1  sticky error flag

## Operation
- Per kernel, a tag shift pipeline of depth PLM_LATENCY. Each stage holds {valid, consumer id}. Stage 0 captures grant_valid[k] & grant_read[k] and grant_consumer[k] each cycle.
- At the last tag stage, the tag lines up with plm_rdata[k] (read data for a grant at cycle t is present on plm_rdata at t+PLM_LATENCY).
- Routing, evaluated every cycle on the last-stage tags:
  - For each consumer c, select the lowest-index kernel whose last-stage tag is valid with id == c.
  - Register resp_valid[c]=1 and resp_data[c]=that kernel's plm_rdata.
  - If no kernel matches c, register resp_valid[c]=0 and resp_data[c]=0.
- Collision: two or more valid last-stage tags with the same id in one cycle.
  - Lowest kernel index wins; the others are dropped.
  - route_error is set.
- Out-of-range id (id ≥ NCONSUMERS, non-power-of-2 NCONSUMERS): the tag is dropped and route_error is set.
- Writes (grant_read=0) and grant_valid=0 enter the pipeline as invalid tags. They produce no response.
- route_error stays 1 until reset.
- The block is fully pipelined: a new grant is accepted on every kernel every cycle, with no backpressure.

## Timing
- Read granted at cycle t (grant_valid & grant_read high at posedge t) → resp_valid/resp_data at the consumer visible after posedge t+PLM_LATENCY+1. Total latency is PLM_LATENCY+1 cycles.
- Throughput: one response per consumer per cycle. Up to min(NKERNELS, NCONSUMERS) responses per cycle in total.
- Reset (synchronous, sampled at posedge):
  - all tag stages invalid
  - resp_valid=0 and resp_data=0 for every consumer
  - route_error=0
- Reset mid-operation: all in-flight tags are discarded and no response for them is ever emitted. Grants presented in the reset cycle are ignored.
- Reset priority: reset overrides any simultaneous grant, delivery, or error.
- The error flag is set at the same posedge that registers the winning response.

## Test plan
- Reset then idle: after reset, resp_valid=0, every resp_data=0, and route_error=0; these hold for 10 idle cycles.
- Single read (NBANKS=1, NPORTS=1, PLM_LATENCY=1, NCONSUMERS=2): grant consumer 1 at t, plm_rdata=0xA5 at t+1 → at t+2, resp_valid=2'b10, resp_data[1]=0xA5, resp_data[0]=0; at t+3, resp_valid=0.
- Back-to-back pipelining (PLM_LATENCY=3): read grants on consecutive cycles to consumers 0,1,0 with data 0x11,0x22,0x33 → responses at t+4, t+5, t+6 in order, each with the correct consumer and value; route_error=0.
- Write filtering: grant_valid=1, grant_read=0 for consumer 0 → no resp_valid at any cycle.
- Collision (NBANKS=2, NPORTS=1): both kernels read for consumer 0 in the same cycle, with data 0x10 (k0) and 0x20 (k1) → resp_data[0]=0x10, resp_valid[0]=1 once, route_error=1 and still 1 after 5 idle cycles.
- Reset mid-flight (PLM_LATENCY=3): read granted at t, reset asserted at t+1 → no response at t+4; route_error=0.

Source files
------------

// File: rtl/rr_response_router_if.sv
// Grant/read-data inputs and per-consumer response outputs of the response router.
interface rr_response_router_if #(
  parameter int VALUE_WIDTH = 8,
  parameter int NCONSUMERS  = 2,
  parameter int NKERNELS    = 1
);
  localparam int CID_WIDTH = (NCONSUMERS > 1) ? $clog2(NCONSUMERS) : 1;

  logic [NKERNELS-1:0]    grant_valid;
  logic [NKERNELS-1:0]    grant_read;
  logic [CID_WIDTH-1:0]   grant_consumer [NKERNELS];
  logic [VALUE_WIDTH-1:0] plm_rdata      [NKERNELS];
  logic [NCONSUMERS-1:0]  resp_valid;
  logic [VALUE_WIDTH-1:0] resp_data      [NCONSUMERS];
  logic                   route_error;

  modport master (
    output grant_valid, grant_read, grant_consumer, plm_rdata,
    input  resp_valid, resp_data, route_error
  );

  modport slave (
    input  grant_valid, grant_read, grant_consumer, plm_rdata,
    output resp_valid, resp_data, route_error
  );
endinterface

// File: rtl/rr_response_router.sv
// Carries consumer tags alongside PLM read latency per kernel and steers read data
// back to the issuing consumer through one registered response port each.
module rr_response_router #(
  parameter int VALUE_WIDTH = 8,
  parameter int NCONSUMERS  = 2,
  parameter int NBANKS      = 1,
  parameter int NPORTS      = 1,
  parameter int PLM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  rr_response_router_if.slave bus
);
  localparam int NKERNELS  = NBANKS * NPORTS;
  localparam int CID_WIDTH = (NCONSUMERS > 1) ? $clog2(NCONSUMERS) : 1;
  localparam int LAST      = PLM_LATENCY - 1;

  if (NPORTS < 1 || NPORTS > 2) begin : g_bad_nports
    $fatal(1, "rr_response_router: NPORTS must be 1 or 2");
  end
  if (PLM_LATENCY < 1) begin : g_bad_latency
    $fatal(1, "rr_response_router: PLM_LATENCY must be >= 1");
  end

  logic [NKERNELS-1:0][PLM_LATENCY-1:0]                vld_pipe_q;
  logic [NKERNELS-1:0][PLM_LATENCY-1:0][CID_WIDTH-1:0] cid_pipe_q;

  logic [NCONSUMERS-1:0]                  resp_valid_q, resp_valid_d;
  logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] resp_data_q,  resp_data_d;
  logic                                   err_q, err_d;

  // Last-stage tags are aligned with plm_rdata; lowest kernel index wins a consumer.
  always_comb begin
    resp_valid_d = '0;
    resp_data_d  = '0;
    err_d        = 1'b0;
    for (int k = 0; k < NKERNELS; k++) begin
      if (vld_pipe_q[k][LAST]) begin
        if (int'(cid_pipe_q[k][LAST]) >= NCONSUMERS) begin
          err_d = 1'b1;
        end else begin
          for (int c = 0; c < NCONSUMERS; c++) begin
            if (cid_pipe_q[k][LAST] == CID_WIDTH'(c)) begin
              if (resp_valid_d[c]) begin
                err_d = 1'b1;
              end else begin
                resp_valid_d[c] = 1'b1;
                resp_data_d[c]  = bus.plm_rdata[k];
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q   <= '0;
      cid_pipe_q   <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      for (int k = 0; k < NKERNELS; k++) begin
        vld_pipe_q[k][0] <= bus.grant_valid[k] & bus.grant_read[k];
        cid_pipe_q[k][0] <= bus.grant_consumer[k];
        for (int s = 1; s < PLM_LATENCY; s++) begin
          vld_pipe_q[k][s] <= vld_pipe_q[k][s-1];
          cid_pipe_q[k][s] <= cid_pipe_q[k][s-1];
        end
      end
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      err_q        <= err_q | err_d;
    end
  end

  assign bus.resp_valid  = resp_valid_q;
  assign bus.route_error = err_q;

  for (genvar c = 0; c < NCONSUMERS; c++) begin : g_resp
    assign bus.resp_data[c] = resp_data_q[c];
  end
endmodule

// File: tb/tb_rr_response_router.sv
// Directed checks: a 2-kernel/3-consumer router at latency 3 driven from a vector
// table, plus a single-kernel latency-1 router exercised by hand.
module tb_rr_response_router;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rr_response_router_if #(.VALUE_WIDTH(8), .NCONSUMERS(2), .NKERNELS(1)) ifa ();
  rr_response_router_if #(.VALUE_WIDTH(8), .NCONSUMERS(3), .NKERNELS(2)) ifb ();

  rr_response_router #(
    .VALUE_WIDTH(8), .NCONSUMERS(2), .NBANKS(1), .NPORTS(1), .PLM_LATENCY(1)
  ) dut_a (.clk(clk), .reset(rst_a), .bus(ifa.slave));

  rr_response_router #(
    .VALUE_WIDTH(8), .NCONSUMERS(3), .NBANKS(2), .NPORTS(1), .PLM_LATENCY(3)
  ) dut_b (.clk(clk), .reset(rst_b), .bus(ifb.slave));

  typedef struct {
    logic       rst;
    logic [1:0] gv, gr, c0, c1;
    logic [7:0] d0, d1;
    logic [2:0] rv;
    logic [7:0] e0, e1, e2;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic [1:0] gv, gr, c0, c1,
                              input logic [7:0] d0, d1, input logic [2:0] rv,
                              input logic [7:0] e0, e1, e2, input logic err);
    vec_t v;
    v.rst = rst; v.gv = gv; v.gr = gr; v.c0 = c0; v.c1 = c1; v.d0 = d0; v.d1 = d1;
    v.rv = rv; v.e0 = e0; v.e1 = e1; v.e2 = e2; v.err = err;
    return v;
  endfunction

  function automatic vec_t idle(input logic err);
    return mk(1'b0, 2'b00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00, err);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic [2:0] rv, input logic [7:0] e0, e1, e2,
                       input logic err);
    chk({tag, ".resp_valid"},  32'(ifb.resp_valid),   32'(rv));
    chk({tag, ".resp_data0"},  32'(ifb.resp_data[0]), 32'(e0));
    chk({tag, ".resp_data1"},  32'(ifb.resp_data[1]), 32'(e1));
    chk({tag, ".resp_data2"},  32'(ifb.resp_data[2]), 32'(e2));
    chk({tag, ".route_error"}, 32'(ifb.route_error),  32'(err));
  endtask

  initial begin
    // Pipelined reads to 0,1,0 on k0 plus a parallel k1 read to consumer 2
    vecs.push_back(mk(0, 2'b11, 2'b11, 2'd0, 2'd2, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk(0, 2'b01, 2'b01, 2'd1, 2'd0, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk(0, 2'b01, 2'b01, 2'd0, 2'd0, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'd0, 2'd0, 8'h11, 8'h44, 3'b101, 8'h11, 8'h00, 8'h44, 0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'd0, 2'd0, 8'h22, 8'h00, 3'b010, 8'h00, 8'h22, 8'h00, 0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'd0, 2'd0, 8'h33, 8'h00, 3'b001, 8'h33, 8'h00, 8'h00, 0));
    // Write on k0, read without valid on k1: neither may respond
    vecs.push_back(mk(0, 2'b01, 2'b10, 2'd0, 2'd1, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(idle(0));
    vecs.push_back(idle(0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'd0, 2'd0, 8'h55, 8'h66, 3'b000, 8'h00, 8'h00, 8'h00, 0));
    // Collision on consumer 0: k0 wins, error sticks through idle, reset clears it
    vecs.push_back(mk(0, 2'b11, 2'b11, 2'd0, 2'd0, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(idle(0));
    vecs.push_back(idle(0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'd0, 2'd0, 8'h10, 8'h20, 3'b001, 8'h10, 8'h00, 8'h00, 1));
    for (int i = 0; i < 5; i++) vecs.push_back(idle(1));
    vecs.push_back(mk(1, 2'b00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00, 0));
    // Reset one cycle after a read; the grant in the reset cycle is ignored too
    vecs.push_back(mk(0, 2'b01, 2'b01, 2'd1, 2'd0, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk(1, 2'b01, 2'b01, 2'd2, 2'd0, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(idle(0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'd0, 2'd0, 8'h77, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'd0, 2'd0, 8'h88, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00, 0));
    // Out-of-range id 3 on k1 is dropped with error; k0 still routes to consumer 1
    vecs.push_back(mk(0, 2'b11, 2'b11, 2'd1, 2'd3, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(idle(0));
    vecs.push_back(idle(0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'd0, 2'd0, 8'hAB, 8'h99, 3'b010, 8'h00, 8'hAB, 8'h00, 1));
    vecs.push_back(idle(1));
    vecs.push_back(mk(1, 2'b00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00, 0));

    ifa.grant_valid = '0; ifa.grant_read = '0; ifa.grant_consumer[0] = '0; ifa.plm_rdata[0] = '0;
    ifb.grant_valid = '0; ifb.grant_read = '0;
    ifb.grant_consumer[0] = '0; ifb.grant_consumer[1] = '0;
    ifb.plm_rdata[0] = '0; ifb.plm_rdata[1] = '0;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk_b($sformatf("idle%0d", i), 3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      rst_b = vecs[i].rst;
      ifb.grant_valid       = vecs[i].gv;
      ifb.grant_read        = vecs[i].gr;
      ifb.grant_consumer[0] = vecs[i].c0;
      ifb.grant_consumer[1] = vecs[i].c1;
      ifb.plm_rdata[0]      = vecs[i].d0;
      ifb.plm_rdata[1]      = vecs[i].d1;
      @(posedge clk); #1;
      chk_b($sformatf("vec%0d", i), vecs[i].rv, vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].err);
    end
    rst_b = 1'b0;

    // Latency-1 single read to consumer 1
    chk("a.reset_valid", 32'(ifa.resp_valid), 32'h0);
    chk("a.reset_error", 32'(ifa.route_error), 32'h0);
    ifa.grant_valid = 1'b1; ifa.grant_read = 1'b1; ifa.grant_consumer[0] = 1'b1;
    @(posedge clk); #1;
    chk("a.t1_valid", 32'(ifa.resp_valid), 32'h0);
    ifa.grant_valid = 1'b0; ifa.grant_read = 1'b0; ifa.grant_consumer[0] = 1'b0;
    ifa.plm_rdata[0] = 8'hA5;
    @(posedge clk); #1;
    chk("a.t2_valid", 32'(ifa.resp_valid),   32'h2);
    chk("a.t2_data1", 32'(ifa.resp_data[1]), 32'hA5);
    chk("a.t2_data0", 32'(ifa.resp_data[0]), 32'h0);
    ifa.plm_rdata[0] = 8'h00;
    @(posedge clk); #1;
    chk("a.t3_valid", 32'(ifa.resp_valid),   32'h0);
    chk("a.t3_data1", 32'(ifa.resp_data[1]), 32'h0);
    chk("a.t3_error", 32'(ifa.route_error),  32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
